// File: rtl/isqrt_iter_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_iter_pkg
// Shared types and default widths for the iterative integer square root engine.
//   state_e   : engine state (IDLE / CALC), 1-bit encoding
//   X_W_DEF   : default radicand width
//   Y_W_DEF   : default result width (X_W_DEF / 2)
// -----------------------------------------------------------------------------
package isqrt_iter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  localparam int X_W_DEF = 32;
  localparam int Y_W_DEF = 16;

endpackage

// File: rtl/isqrt_iter_step.sv
// -----------------------------------------------------------------------------
// isqrt_iter_step
// One digit-by-digit square root iteration, purely combinational.
// Ports:
//   rem_i   [Y_W+1:0]  partial remainder before this step
//   root_i  [Y_W-1:0]  partial root before this step
//   digit_i [1:0]      next radicand bit pair (most significant first)
//   rem_o   [Y_W+1:0]  partial remainder after this step
//   root_o  [Y_W-1:0]  partial root after this step
// -----------------------------------------------------------------------------
module isqrt_iter_step
  import isqrt_iter_pkg::*;
#(
  parameter int Y_W = Y_W_DEF
) (
  input  logic [Y_W+1:0] rem_i,
  input  logic [Y_W-1:0] root_i,
  input  logic [1:0]     digit_i,
  output logic [Y_W+1:0] rem_o,
  output logic [Y_W-1:0] root_o
);

  // Compare at full width so no remainder bit is lost before the decision;
  // the true remainder always fits back into Y_W+2 bits.
  logic [Y_W+3:0] rem_sh_s;
  logic [Y_W+3:0] trial_s;

  // Trial subtraction of (root<<2)|1 from the shifted-in remainder.
  always_comb begin
    rem_sh_s = {rem_i, digit_i};
    trial_s  = {2'b00, root_i, 2'b01};
    if (rem_sh_s >= trial_s) begin
      rem_o  = rem_sh_s[Y_W+1:0] - trial_s[Y_W+1:0];
      root_o = {root_i[Y_W-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh_s[Y_W+1:0];
      root_o = {root_i[Y_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// -----------------------------------------------------------------------------
// isqrt_iter_fsm
// Iterative integer square root, y = floor(sqrt(x)), one result bit per clock.
// Fixed latency of X_W/2 cycles from acceptance to y_vld, no backpressure.
// A request is accepted in the same cycle a result is returned.
//
// Optional build macro: ISQRT_ITER_RESTART_EN
//   defined   : x_vld while busy aborts the current computation and restarts
//   undefined : x_vld while busy is ignored
//
// Ports:
//   clk    in           clock
//   rst    in           synchronous active-high reset
//   x_vld  in           request strobe (single-cycle pulse)
//   x      in  [X_W]    radicand, sampled only on acceptance
//   y_vld  out          registered single-cycle result strobe
//   y      out [X_W/2]  registered result, held until the next result
//   busy   out          registered, high while an iteration is in progress
// -----------------------------------------------------------------------------
module isqrt_iter_fsm
  import isqrt_iter_pkg::*;
#(
  parameter  int X_W = X_W_DEF,
  localparam int Y_W = X_W / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x_vld,
  input  logic [X_W-1:0] x,
  output logic           y_vld,
  output logic [Y_W-1:0] y,
  output logic           busy
);

  localparam int LATENCY = X_W / 2;
  localparam int CNT_W   = $clog2(LATENCY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W+1:0]   rem_q, rem_d;
  logic [Y_W-1:0]   root_q, root_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             y_vld_q, y_vld_d;
  logic             busy_q, busy_d;

  logic             accept_s;
  logic [Y_W+1:0]   step_rem_in_s;
  logic [Y_W-1:0]   step_root_in_s;
  logic [1:0]       step_digit_s;
  logic [Y_W+1:0]   step_rem_out_s;
  logic [Y_W-1:0]   step_root_out_s;

  isqrt_iter_step #(.Y_W(Y_W)) u_step (
    .rem_i   (step_rem_in_s),
    .root_i  (step_root_in_s),
    .digit_i (step_digit_s),
    .rem_o   (step_rem_out_s),
    .root_o  (step_root_out_s)
  );

  // Next-state logic: acceptance, iteration and result hand-off.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    root_d         = root_q;
    x_d            = x_q;
    y_d            = y_q;
    y_vld_d        = 1'b0;
    step_rem_in_s  = rem_q;
    step_root_in_s = root_q;
    step_digit_s   = x_q[X_W-1 -: 2];

`ifdef ISQRT_ITER_RESTART_EN
    accept_s = x_vld;
`else
    accept_s = x_vld && (state_q == IDLE);
`endif

    if (accept_s) begin
      // The first iteration runs on the acceptance edge straight from x,
      // starting from a cleared remainder and root.
      step_rem_in_s  = {(Y_W+2){1'b0}};
      step_root_in_s = {Y_W{1'b0}};
      step_digit_s   = x[X_W-1 -: 2];
      x_d            = {x[X_W-3:0], 2'b00};
      rem_d          = step_rem_out_s;
      root_d         = step_root_out_s;
      cnt_d          = CNT_W'(LATENCY - 1);
      state_d        = CALC;
    end else if (state_q == CALC) begin
      x_d    = {x_q[X_W-3:0], 2'b00};
      rem_d  = step_rem_out_s;
      root_d = step_root_out_s;
      if (cnt_q == CNT_W'(1)) begin
        // Last iteration: publish the root and free the engine so a new
        // request can be taken in the y_vld cycle.
        cnt_d   = {CNT_W{1'b0}};
        y_d     = step_root_out_s;
        y_vld_d = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      state_d = IDLE;
    end

    busy_d = (state_d == CALC);
  end

  // State and output registers with synchronous reset (aborts any computation).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rem_q   <= {(Y_W+2){1'b0}};
      root_q  <= {Y_W{1'b0}};
      x_q     <= {X_W{1'b0}};
      y_q     <= {Y_W{1'b0}};
      y_vld_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      x_q     <= x_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      busy_q  <= busy_d;
    end
  end

  assign y_vld = y_vld_q;
  assign y     = y_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// -----------------------------------------------------------------------------
// tb_isqrt_iter_fsm
// Directed self-checking bench for isqrt_iter_fsm (default X_W=32).
// Honours ISQRT_ITER_RESTART_EN for the request-while-busy case.
// -----------------------------------------------------------------------------
module tb_isqrt_iter_fsm;

  localparam int LAT = 16;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  logic        busy;

  int total_cnt;
  int bad_cnt;

  isqrt_iter_fsm #(.X_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .busy  (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference floor(sqrt) by greedy bit setting on squares.
  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    logic [15:0] r;
    logic [15:0] c;
    r = 16'd0;
    for (int b = 15; b >= 0; b--) begin
      c = r | (16'd1 << b);
      if ({32'd0, c} * {32'd0, c} <= {32'd0, v}) r = c;
    end
    return r;
  endfunction

  // Issue a request in the current cycle and check every cycle up to the
  // result; returns in the y_vld cycle so a following call is back-to-back.
  task automatic do_req(input logic [31:0] xv, input logic [15:0] ye, input string tag);
    x_vld = 1'b1;
    x     = xv;
    tick();
    x_vld = 1'b0;
    x     = 32'hDEAD_BEEF;
    for (int r = 1; r < LAT; r++) begin
      check($sformatf("%s_busy_c%0d", tag, r), {30'd0, busy, y_vld}, 32'd2);
      tick();
    end
    check($sformatf("%s_vld", tag), {30'd0, busy, y_vld}, 32'd1);
    check($sformatf("%s_y", tag), {16'd0, y}, {16'd0, ye});
  endtask

  initial begin
    logic [31:0] rv;
    logic        exp_vld;
    logic        exp_busy;
    total_cnt = 0;
    bad_cnt   = 0;
    rst   = 1'b1;
    x_vld = 1'b0;
    x     = 32'd0;
    tick();
    tick();
    check("rst_vld", {31'd0, y_vld}, 32'd0);
    check("rst_y", {16'd0, y}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Basic request and hold behaviour.
    do_req(32'd16, 16'd4, "x16");
    tick();
    check("x16_hold_vld", {31'd0, y_vld}, 32'd0);
    check("x16_hold_y", {16'd0, y}, 32'd4);
    check("x16_hold_busy", {31'd0, busy}, 32'd0);
    tick();

    // Sequential requests incl. boundaries.
    do_req(32'd0, 16'd0, "x0");
    tick();
    do_req(32'd15, 16'd3, "x15");
    tick();
    do_req(32'hFFFF_FFFF, 16'hFFFF, "xmax");
    tick();
    do_req(32'hFFFE_0001, 16'hFFFF, "sq_ffff");
    tick();
    do_req(32'hFFFE_0000, 16'hFFFE, "sq_ffff_m1");
    tick();
    do_req(32'd1, 16'd1, "x1");
    tick();
    do_req(32'd3, 16'd1, "x3");
    tick();
    do_req(32'd1000000, 16'd1000, "x1e6");
    tick();

    // Back-to-back: second request driven in the y_vld cycle.
    do_req(32'd100, 16'd10, "b2b_100");
    do_req(32'd81, 16'd9, "b2b_81");
    tick();

    // Chained dependent requests (256 -> 16 -> 4 -> 2).
    do_req(32'd256, 16'd16, "ch_256");
    do_req(32'd16, 16'd4, "ch_16");
    do_req(32'd4, 16'd2, "ch_4");
    tick();

    // Request while busy at cycle 8.
    x_vld = 1'b1;
    x     = 32'd49;
    tick();
    x_vld = 1'b0;
    for (int r = 1; r <= 24; r++) begin
`ifdef ISQRT_ITER_RESTART_EN
      exp_vld  = (r == 24);
      exp_busy = (r < 24);
`else
      exp_vld  = (r == 16);
      exp_busy = (r < 16);
`endif
      check($sformatf("rb_c%0d", r), {30'd0, busy, y_vld}, {30'd0, exp_busy, exp_vld});
`ifdef ISQRT_ITER_RESTART_EN
      if (r == 24) check("rb_y", {16'd0, y}, 32'd2);
`else
      if (r == 16) check("rb_y", {16'd0, y}, 32'd7);
`endif
      if (r == 8) begin
        x_vld = 1'b1;
        x     = 32'd4;
      end
      tick();
      x_vld = 1'b0;
    end

    // Reset mid-computation at cycle 10, new request at cycle 12.
    x_vld = 1'b1;
    x     = 32'd200;
    tick();
    x_vld = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_vld", {31'd0, y_vld}, 32'd0);
    check("mrst_y", {16'd0, y}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    tick();
    do_req(32'd144, 16'd12, "post_rst");
    tick();

    // Random cross-check against the reference model.
    for (int i = 0; i < 8; i++) begin
      rv = $urandom;
      do_req(rv, ref_isqrt(rv), $sformatf("rnd%0d", i));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/isqrt_iter_fsm.md
Name: isqrt_iter_fsm

Overview:
Iterative integer square root engine, y = floor(sqrt(x)). It sits directly downstream of the formula FSMs and serves their isqrt_x/isqrt_y request/response interface.
- One shared instance serves one formula FSM.
- Computes one result bit per clock with a single digit-by-digit step datapath, trading latency for area.
- Fixed latency, no backpressure.
- Accepts a new request in the same cycle it returns a result, so chained FSMs can issue back-to-back dependent requests.

Parameters:
- X_W, 32: input width; must be even and at least 4.
- Y_W, X_W/2: result width; localparam, not overridable.
- LATENCY, X_W/2: cycles from acceptance to y_vld; localparam, equal to the iteration count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- x_vld  in  1  request strobe; single-cycle pulse.
- x  in  X_W  radicand; sampled only in the cycle the request is accepted.
- y_vld  out  1  result strobe; registered, single-cycle pulse.
- y  out  Y_W  floor(sqrt(x)); registered; holds its value until the next result.
- busy  out  1  high while an iteration is in progress; registered.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; y_vld=0, y=0, busy=0.
  - Iteration counter, remainder and partial root cleared.
  - Applies mid-operation too: the computation is aborted and no y_vld is issued.
- States:
  - IDLE: accepts a request when x_vld=1. Next state is CALC.
  - CALC: iterates. After the last iteration, next state is IDLE.
- Acceptance: x_vld sampled high in cycle k while state=IDLE → y_vld=1 in exactly cycle k+LATENCY (k+16 for the default).
  - The first iteration is performed on the acceptance edge.
  - busy=1 in cycles k+1 .. k+LATENCY-1.
- Result:
  - y_vld and the new y are driven from registers in the same cycle.
  - Next cycle y_vld=0 and y is held.
- Back-to-back: state is already IDLE in the y_vld cycle, so x_vld in that same cycle is accepted. The next y_vld follows LATENCY cycles later.
- x_vld while busy=1 is ignored; the in-flight computation is unaffected.
- Iteration i = LATENCY-1 down to 0 (rem is Y_W+2 bits, root is Y_W bits):
  - rem' = (rem<<2) | x[2i+1:2i]
  - t = (root<<2) | 1
  - if rem' >= t: rem = rem'-t, root = (root<<1)|1
  - else: rem = rem', root = root<<1
- y = root after the final iteration.
- Boundaries: x=0 → y=0; x=2^X_W-1 → y=2^Y_W-1. No overflow is possible at the declared widths.
- Counter: the iteration counter counts down from LATENCY-1 with no wrap-around. Reaching 0 in CALC terminates the computation.

Optional Feature:
- Macro ISQRT_ITER_RESTART_EN.
- Defined: x_vld while busy=1 aborts the current computation and restarts with the new x.
  - This is treated as acceptance in that cycle, so y_vld comes LATENCY cycles after the restart.
  - No y_vld is issued for the aborted request.
- Undefined: x_vld while busy=1 is ignored, as described under Behaviour.

Decomposition:
- Package isqrt_iter_pkg:
  - state enum type (IDLE, CALC), 1-bit encoding;
  - default widths X_W_DEF=32 and Y_W_DEF=16.
- Sub-module isqrt_iter_step:
  - purely combinational single iteration;
  - inputs rem, root, 2-bit digit pair; outputs next rem and next root;
  - instantiated once in the top.

Test Plan:
- x=16 accepted in cycle 5 → y_vld=1 and y=4 in cycle 21 only; busy=1 in cycles 6-20.
- Sequential requests x=0, 15, 0xFFFFFFFF → y=0, 3, 0xFFFF, each exactly 16 cycles after its acceptance.
- Back-to-back: x=100 in cycle 0, x=81 driven in the y_vld cycle 16 → y=10 at cycle 16, y=9 at cycle 32.
- x=49 accepted, then x=4 pulsed while busy (cycle 8):
  - macro undefined → y=7 at cycle 16 only;
  - macro defined → no pulse at 16, y=2 at cycle 24.
- rst pulsed at cycle 10 of a computation → no y_vld ever for that request; y=0; a new request in cycle 12 returns correctly at cycle 28.
- Closed loop with formula_2_fsm, a=0, b=0, c=256 → isqrt inputs 256, 16, 4; formula res=2.
- Randomized cross-check against a reference floor(sqrt) model.
